// File: rtl/mem_block_responder.sv
// Shared backing memory behind the icache and dcache.
// Fixed-latency block responder, dcache has priority.
module mem_block_responder #(
  parameter int ADDR_W  = 28,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [127:0]      i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [127:0]      d_writedata,
  output logic [127:0]      d_readdata,
  output logic              d_busywait
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    ACK
  } state_t;

  state_t             state;
  logic               grant_d;
  logic               op_write;
  logic [IDX_W-1:0]   idx;
  logic [127:0]       wdata;
  logic [CNT_W-1:0]   cnt;
  logic [127:0]       mem [DEPTH];

  logic d_req;
  logic g_req;
  logic done;

  assign d_req = d_read | d_write;
  assign g_req = grant_d ? d_req : i_read;
  assign done  = (state == SERVE) && g_req && (cnt == '0);

  assign i_busywait = i_read & ~((state == ACK) & ~grant_d);
  assign d_busywait = d_req & ~((state == ACK) & grant_d);

  generate
    if (ADDR_W > IDX_W) begin : g_alias
      logic unused_hi;
      assign unused_hi = ^{i_address[ADDR_W-1:IDX_W],
                           d_address[ADDR_W-1:IDX_W]};
    end
  endgenerate

  // Arbitration, latency count and readdata capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_d    <= 1'b0;
      cnt        <= '0;
      i_readdata <= '0;
      d_readdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (d_req) begin
            grant_d  <= 1'b1;
            op_write <= d_write;
            idx      <= d_address[IDX_W-1:0];
            wdata    <= d_writedata;
            cnt      <= CNT_LOAD;
            state    <= SERVE;
          end else if (i_read) begin
            grant_d  <= 1'b0;
            op_write <= 1'b0;
            idx      <= i_address[IDX_W-1:0];
            wdata    <= d_writedata;
            cnt      <= CNT_LOAD;
            state    <= SERVE;
          end
        end
        SERVE: begin
          if (!g_req) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= ACK;
            if (!op_write) begin
              if (grant_d) d_readdata <= mem[idx];
              else         i_readdata <= mem[idx];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Block write on the final SERVE edge of a write access.
  always_ff @(posedge clk) begin
    if (!reset && done && op_write) mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_mem_block_responder.sv
// Scoreboard bench for mem_block_responder.
// LATENCY=4, DEPTH=256.
module tb_mem_block_responder;

  localparam int AW = 28;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [127:0]  i_readdata;
  logic          i_busywait;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [127:0]  d_writedata;
  logic [127:0]  d_readdata;
  logic          d_busywait;

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] model [256];
  logic [127:0] exp_i_q [$];
  logic [127:0] exp_d_q [$];
  logic [127:0] d_hold;
  logic [127:0] i_hold;

  mem_block_responder #(
    .ADDR_W(AW), .DEPTH(256), .LATENCY(4)
  ) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address),
    .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write),
    .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait)
  );

  always #5 clk = ~clk;

  task automatic d_txn(input logic rd, input logic wr,
                       input logic [AW-1:0] a,
                       input logic [127:0] wd,
                       output int cyc,
                       output logic [127:0] rdat);
    @(posedge clk); #1;
    d_read = rd; d_write = wr;
    d_address = a; d_writedata = wd;
    cyc = -1; rdat = 'x;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!d_busywait) begin
        cyc = c; rdat = d_readdata; break;
      end
    end
    @(posedge clk); #1;
    d_read = 0; d_write = 0;
  endtask

  task automatic i_txn(input logic [AW-1:0] a,
                       output int cyc,
                       output logic [127:0] rdat);
    @(posedge clk); #1;
    i_read = 1; i_address = a;
    cyc = -1; rdat = 'x;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!i_busywait) begin
        cyc = c; rdat = i_readdata; break;
      end
    end
    @(posedge clk); #1;
    i_read = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    vectors++;
    if (i_readdata !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_i_readdata got %h want 0", i_readdata);
    end
    vectors++;
    if (d_readdata !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_d_readdata got %h want 0", d_readdata);
    end
    vectors++;
    if ({i_busywait, d_busywait} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_busywait got %b want 00",
               {i_busywait, d_busywait});
    end
    d_hold = 0; i_hold = 0;
  endtask

  task automatic test_write_read;
    int cyc;
    logic [127:0] r, e, blk;
    blk = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    model[8'h05] = blk;
    d_txn(0, 1, 28'h05, blk, cyc, r);
    vectors++;
    if (cyc !== 5) begin
      miscompares++;
      $display("FAIL write_latency got %0d want 5", cyc);
    end
    exp_d_q.push_back(model[8'h05]);
    d_txn(1, 0, 28'h05, '0, cyc, r);
    e = exp_d_q.pop_front();
    d_hold = e;
    vectors++;
    if (cyc !== 5) begin
      miscompares++;
      $display("FAIL read_latency got %0d want 5", cyc);
    end
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL read_data got %h want %h", r, e);
    end
  endtask

  task automatic test_alias;
    int cyc;
    logic [127:0] r, e;
    exp_i_q.push_back(model[8'h05]);
    i_txn(28'h105, cyc, r);
    e = exp_i_q.pop_front();
    i_hold = e;
    vectors++;
    if (cyc !== 5) begin
      miscompares++;
      $display("FAIL alias_latency got %0d want 5", cyc);
    end
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL alias_data got %h want %h", r, e);
    end
    vectors++;
    if (d_readdata !== d_hold) begin
      miscompares++;
      $display("FAIL alias_d_hold got %h want %h",
               d_readdata, d_hold);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, d_done, i_done;
    logic i_bw_at_d;
    logic [127:0] r, gd, gi, ed, ei;
    model[8'h10] = {4{32'h1111_0010}};
    model[8'h20] = {4{32'h2222_0020}};
    d_txn(0, 1, 28'h10, model[8'h10], cyc, r);
    d_txn(0, 1, 28'h20, model[8'h20], cyc, r);
    @(posedge clk); #1;
    i_read = 1; i_address = 28'h10;
    d_read = 1; d_address = 28'h20;
    exp_d_q.push_back(model[8'h20]);
    exp_i_q.push_back(model[8'h10]);
    d_done = -1; i_done = -1; i_bw_at_d = 0;
    gd = 'x; gi = 'x;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (d_done < 0 && !d_busywait) begin
        d_done = c; gd = d_readdata;
        i_bw_at_d = i_busywait;
      end
      if (i_done < 0 && !i_busywait) begin
        i_done = c; gi = i_readdata;
      end
      if (i_done >= 0) break;
      @(posedge clk); #1;
      if (d_done >= 0) d_read = 0;
    end
    @(posedge clk); #1;
    i_read = 0; d_read = 0;
    ed = exp_d_q.pop_front();
    ei = exp_i_q.pop_front();
    d_hold = ed; i_hold = ei;
    vectors++;
    if (d_done !== 5) begin
      miscompares++;
      $display("FAIL arb_d_latency got %0d want 5", d_done);
    end
    vectors++;
    if (i_bw_at_d !== 1'b1) begin
      miscompares++;
      $display("FAIL arb_i_stall got %b want 1", i_bw_at_d);
    end
    vectors++;
    if (i_done !== 11) begin
      miscompares++;
      $display("FAIL arb_i_latency got %0d want 11", i_done);
    end
    vectors++;
    if (gd !== ed) begin
      miscompares++;
      $display("FAIL arb_d_data got %h want %h", gd, ed);
    end
    vectors++;
    if (gi !== ei) begin
      miscompares++;
      $display("FAIL arb_i_data got %h want %h", gi, ei);
    end
  endtask

  task automatic test_withdraw;
    int cyc;
    logic [127:0] r, e;
    @(posedge clk); #1;
    d_write = 1; d_address = 28'h07;
    d_writedata = 128'h1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_write = 0;
    @(negedge clk);
    vectors++;
    if (d_busywait !== 1'b0) begin
      miscompares++;
      $display("FAIL withdraw_bw got %b want 0", d_busywait);
    end
    repeat (3) @(posedge clk);
    exp_d_q.push_back(model[8'h07]);
    d_txn(1, 0, 28'h07, '0, cyc, r);
    e = exp_d_q.pop_front();
    d_hold = e;
    vectors++;
    if (cyc !== 5) begin
      miscompares++;
      $display("FAIL withdraw_idle got %0d want 5", cyc);
    end
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL withdraw_data got %h want %h", r, e);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [127:0] r, e;
    exp_d_q.push_back(model[8'h05]);
    d_txn(1, 0, 28'h05, '0, cyc, r);
    e = exp_d_q.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL pre_reset_data got %h want %h", r, e);
    end
    @(posedge clk); #1;
    d_write = 1; d_address = 28'h09;
    d_writedata = {4{32'h9999_9999}};
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1; d_write = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    vectors++;
    if (d_readdata !== 128'd0) begin
      miscompares++;
      $display("FAIL midreset_d_readdata got %h want 0",
               d_readdata);
    end
    vectors++;
    if (i_readdata !== 128'd0) begin
      miscompares++;
      $display("FAIL midreset_i_readdata got %h want 0",
               i_readdata);
    end
    exp_d_q.push_back(model[8'h09]);
    d_txn(1, 0, 28'h09, '0, cyc, r);
    e = exp_d_q.pop_front();
    vectors++;
    if (cyc !== 5) begin
      miscompares++;
      $display("FAIL midreset_idle got %0d want 5", cyc);
    end
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL midreset_block got %h want %h", r, e);
    end
  endtask

  task automatic test_rw_both;
    int cyc;
    logic [127:0] r, e, aa;
    aa = {16{8'hAA}};
    model[8'h0A] = aa;
    d_txn(1, 1, 28'h0A, aa, cyc, r);
    vectors++;
    if (cyc !== 5) begin
      miscompares++;
      $display("FAIL rw_latency got %0d want 5", cyc);
    end
    exp_d_q.push_back(model[8'h0A]);
    d_txn(1, 0, 28'h0A, '0, cyc, r);
    e = exp_d_q.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL rw_data got %h want %h", r, e);
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) model[k] = '0;
    reset = 1; i_read = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; d_writedata = '0;
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_withdraw();
    test_reset_mid();
    test_rw_both();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
